// File: rtl/rf_write_queue.sv
// In-order write-request buffer feeding the 16x32 register file write port.
// Optional read bypass is built when RF_WRITE_QUEUE_BYPASS_EN is defined.
module rf_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [DW-1:0]              in_data,
  input  logic                       rf_stall,
  output logic                       rf_ld,
  output logic [AW-1:0]              rf_addr,
  output logic [DW-1:0]              rf_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic [AW-1:0]              byp_addr,
  output logic                       byp_hit,
  output logic [DW-1:0]              byp_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push;
  logic          pop;

  assign count    = cnt_q;
  assign in_ready = (cnt_q != CW'(DEPTH)) && rst_n;
  assign rf_ld    = (cnt_q != '0) && !rf_stall;
  assign rf_addr  = mem_addr[rd_ptr];
  assign rf_data  = mem_data[rd_ptr];
  assign push     = in_valid && in_ready;
  assign pop      = rf_ld;

  // Entry storage is deliberately left out of reset; occupancy gates validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef RF_WRITE_QUEUE_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Scan oldest to newest so the last occupied match (newest) wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = rd_ptr;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      byp_idx = rd_ptr + PW'(k);
      if ((CW'(k) < cnt_q) && (mem_addr[byp_idx] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = mem_data[byp_idx];
      end
    end
  end
`else
  logic byp_unused;
  assign byp_unused = ^byp_addr;
  assign byp_hit    = 1'b0;
  assign byp_data   = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed table-driven bench for rf_write_queue (DEPTH 4) plus reset sequences.
module tb_rf_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_stall;
  logic        rf_ld;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [2:0]  count;
  logic [3:0]  byp_addr;
  logic        byp_hit;
  logic [31:0] byp_data;

  int checks   = 0;
  int failures = 0;

`ifdef RF_WRITE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_write_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .rf_stall(rf_stall), .rf_ld(rf_ld), .rf_addr(rf_addr), .rf_data(rf_data),
    .count(count), .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [31:0] d;
    logic        st;
    logic [3:0]  ba;
    logic        e_rdy;
    logic        e_ld;
    logic [2:0]  e_cnt;
    logic        chk_head;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic        e_hit;
    logic [31:0] e_bdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [3:0] a, input logic [31:0] d, input logic st,
                     input logic [3:0] ba, input logic rdy, input logic ld, input logic [2:0] cnt,
                     input logic ch, input logic [3:0] ea, input logic [31:0] ed,
                     input logic hit, input logic [31:0] bd);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.st = st; r.ba = ba;
    r.e_rdy = rdy; r.e_ld = ld; r.e_cnt = cnt; r.chk_head = ch;
    r.e_addr = ea; r.e_data = ed; r.e_hit = hit; r.e_bdata = bd;
    vecs.push_back(r);
  endtask

  initial begin
    // single write
    add(1, 4'd3, 32'hFFFFFF00, 0, 4'd0, 1, 0, 3'd0, 0, 4'd0, 32'h0,        0, 32'h0);
    add(0, 4'd0, 32'h0,        0, 4'd0, 1, 1, 3'd1, 1, 4'd3, 32'hFFFFFF00, 0, 32'h0);
    add(0, 4'd0, 32'h0,        0, 4'd0, 1, 0, 3'd0, 0, 4'd0, 32'h0,        0, 32'h0);
    // fill while stalled, then drain in order
    add(1, 4'd0, 32'h10, 1, 4'd9, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);
    add(1, 4'd1, 32'h11, 1, 4'd9, 1, 0, 3'd1, 1, 4'd0, 32'h10, 0, 32'h0);
    add(1, 4'd2, 32'h12, 1, 4'd9, 1, 0, 3'd2, 1, 4'd0, 32'h10, 0, 32'h0);
    add(1, 4'd3, 32'h13, 1, 4'd9, 1, 0, 3'd3, 1, 4'd0, 32'h10, 0, 32'h0);
    add(1, 4'd9, 32'h99, 1, 4'd9, 0, 0, 3'd4, 1, 4'd0, 32'h10, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 0, 1, 3'd4, 1, 4'd0, 32'h10, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd3, 1, 4'd1, 32'h11, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd2, 1, 4'd2, 32'h12, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd1, 1, 4'd3, 32'h13, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);
    // full queue with pop: push refused that cycle, accepted next; wraps pointers
    add(1, 4'd4, 32'h20, 1, 4'd9, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);
    add(1, 4'd5, 32'h21, 1, 4'd9, 1, 0, 3'd1, 1, 4'd4, 32'h20, 0, 32'h0);
    add(1, 4'd6, 32'h22, 1, 4'd9, 1, 0, 3'd2, 1, 4'd4, 32'h20, 0, 32'h0);
    add(1, 4'd7, 32'h23, 1, 4'd9, 1, 0, 3'd3, 1, 4'd4, 32'h20, 0, 32'h0);
    add(1, 4'd8, 32'h24, 0, 4'd9, 0, 1, 3'd4, 1, 4'd4, 32'h20, 0, 32'h0);
    add(1, 4'd8, 32'h24, 0, 4'd9, 1, 1, 3'd3, 1, 4'd5, 32'h21, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd3, 1, 4'd6, 32'h22, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd2, 1, 4'd7, 32'h23, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 1, 3'd1, 1, 4'd8, 32'h24, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd9, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);
    // bypass: newest match wins, same-cycle push invisible, draining head still visible
    add(1, 4'd5, 32'h11, 1, 4'd5, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);
    add(1, 4'd5, 32'h22, 1, 4'd5, 1, 0, 3'd1, 1, 4'd5, 32'h11, 1, 32'h11);
    add(0, 4'd0, 32'h0,  1, 4'd5, 1, 0, 3'd2, 1, 4'd5, 32'h11, 1, 32'h22);
    add(0, 4'd0, 32'h0,  1, 4'd6, 1, 0, 3'd2, 1, 4'd5, 32'h11, 0, 32'h0);
    add(0, 4'd0, 32'h0,  0, 4'd5, 1, 1, 3'd2, 1, 4'd5, 32'h11, 1, 32'h22);
    add(0, 4'd0, 32'h0,  0, 4'd5, 1, 1, 3'd1, 1, 4'd5, 32'h22, 1, 32'h22);
    add(0, 4'd0, 32'h0,  0, 4'd5, 1, 0, 3'd0, 0, 4'd0, 32'h0,  0, 32'h0);

    // reset then idle
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; rf_stall = 1'b0; byp_addr = '0;
    next_cycle();
    next_cycle();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rf_ld",    {31'd0, rf_ld},    32'd0);
    chk("rst_count",    {29'd0, count},    32'd0);
    chk("rst_byp_hit",  {31'd0, byp_hit},  32'd0);
    chk("rst_byp_data", byp_data,          32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    next_cycle();

    foreach (vecs[i]) begin
      in_valid = vecs[i].v; in_addr = vecs[i].a; in_data = vecs[i].d;
      rf_stall = vecs[i].st; byp_addr = vecs[i].ba;
      #2;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_rf_ld", i),    {31'd0, rf_ld},    {31'd0, vecs[i].e_ld});
      chk($sformatf("v%0d_count", i),    {29'd0, count},    {29'd0, vecs[i].e_cnt});
      if (vecs[i].chk_head) begin
        chk($sformatf("v%0d_rf_addr", i), {28'd0, rf_addr}, {28'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_rf_data", i), rf_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d_byp_hit", i),  {31'd0, byp_hit}, {31'd0, vecs[i].e_hit & BYP});
      chk($sformatf("v%0d_byp_data", i), byp_data, BYP ? vecs[i].e_bdata : 32'd0);
      next_cycle();
    end

    // reset mid-drain: three entries stalled, then reset pulsed between edges
    rf_stall = 1'b1; in_valid = 1'b1;
    in_addr = 4'hA; in_data = 32'hA0; next_cycle();
    in_addr = 4'hB; in_data = 32'hB0; next_cycle();
    in_addr = 4'hC; in_data = 32'hC0; next_cycle();
    in_valid = 1'b0; rf_stall = 1'b0;
    #1;
    chk("mid_pre_ld",    {31'd0, rf_ld}, 32'd1);
    chk("mid_pre_count", {29'd0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ld",    {31'd0, rf_ld},    32'd0);
    chk("mid_rst_count", {29'd0, count},    32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    next_cycle();
    chk("mid_post_count", {29'd0, count}, 32'd0);
    in_valid = 1'b1; in_addr = 4'hE; in_data = 32'hDEAD;
    next_cycle();
    in_valid = 1'b0;
    #1;
    chk("mid_first_ld",    {31'd0, rf_ld},   32'd1);
    chk("mid_first_addr",  {28'd0, rf_addr}, 32'hE);
    chk("mid_first_data",  rf_data,          32'hDEAD);
    chk("mid_first_count", {29'd0, count},   32'd1);
    next_cycle();
    chk("mid_empty_count", {29'd0, count}, 32'd0);
    chk("mid_empty_ld",    {31'd0, rf_ld}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
